softmax_sum_normalize: RTL and testbench

Front-end and back-end of the 32-element softmax datapath around the reciprocal unit. It accepts a stream of exp values, buffers them and accumulates their Q6.26 sum. It issues that sum as a single-cycle request to the reciprocal unit, then waits for the Q0.16 reciprocal. Finally it streams out the normalized probabilities, each exp × 1/sum, with valid/ready handshaking.

---
 rtl/softmax_sum_normalize.sv | 147 ++++++++++++++
 tb/tb_softmax_sum_normalize.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/softmax_sum_normalize.sv
// Softmax front/back end: buffers 32 exp values, issues their Q6.26 sum to the
// reciprocal unit, then streams exp * (1/sum) as rounded Q0.16 probabilities.
module softmax_sum_normalize #(
  parameter int NUM_ELEMS   = 32,
  parameter int EXP_WIDTH   = 16,
  parameter int SUM_WIDTH   = 32,
  parameter int RECIP_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_exp_valid,
  input  logic [EXP_WIDTH-1:0]   i_exp,
  output logic                   o_exp_ready,
  output logic                   o_sum_valid,
  output logic [SUM_WIDTH-1:0]   o_sum,
  input  logic                   i_recip_valid,
  input  logic [RECIP_WIDTH-1:0] i_recip,
  output logic                   o_prob_valid,
  output logic [EXP_WIDTH-1:0]   o_prob,
  output logic                   o_prob_last,
  input  logic                   i_prob_ready,
  output logic                   o_busy
);

  localparam int CNT_W  = $clog2(NUM_ELEMS);
  localparam int IDX_W  = CNT_W + 1;
  localparam int PROD_W = EXP_WIDTH + RECIP_WIDTH;

  typedef enum logic [1:0] {
    S_ACCUM,
    S_ISSUE,
    S_WAIT,
    S_NORM
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [RECIP_WIDTH-1:0] recip_q;
  logic [SUM_WIDTH-1:0]   accum_q;
  logic [SUM_WIDTH-1:0]   sum_q;
  logic                   sumValid_q;
  logic [EXP_WIDTH-1:0]   prob_q;
  logic                   probValid_q;
  logic                   probLast_q;
  logic [EXP_WIDTH-1:0]   expBuf_q [NUM_ELEMS];

  logic                   expFire;
  logic                   lastExp;
  logic [SUM_WIDTH-1:0]   expTerm;
  logic [SUM_WIDTH-1:0]   accum_d;
  logic                   canLoad;
  logic                   lastOut;
  logic [EXP_WIDTH-1:0]   bufRd;
  logic [PROD_W-1:0]      roundProd;
  logic [EXP_WIDTH-1:0]   prob_d;

  assign expFire = i_exp_valid && (state_q == S_ACCUM);
  assign lastExp = (cnt_q == CNT_W'(NUM_ELEMS - 1));
  // Q0.16 -> Q6.26 alignment; the first element of a vector reloads the sum.
  assign expTerm = {{(SUM_WIDTH - EXP_WIDTH){1'b0}}, i_exp} << 10;
  assign accum_d = (cnt_q == '0) ? expTerm : accum_q + expTerm;

  // Max product 0xFFFE0001 plus the half-LSB still fits in PROD_W bits.
  assign bufRd     = expBuf_q[idx_q[CNT_W-1:0]];
  assign roundProd = PROD_W'(bufRd) * PROD_W'(recip_q) + PROD_W'(1 << (RECIP_WIDTH - 1));
  assign prob_d    = EXP_WIDTH'(roundProd >> RECIP_WIDTH);

  assign canLoad = (state_q == S_NORM) && (idx_q < IDX_W'(NUM_ELEMS)) &&
                   (!probValid_q || i_prob_ready);
  assign lastOut = probValid_q && probLast_q && i_prob_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_ACCUM;
      cnt_q       <= '0;
      idx_q       <= '0;
      recip_q     <= '0;
      accum_q     <= '0;
      sum_q       <= '0;
      sumValid_q  <= 1'b0;
      prob_q      <= '0;
      probValid_q <= 1'b0;
      probLast_q  <= 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (expFire) begin
            accum_q <= accum_d;
            cnt_q   <= cnt_q + 1'b1;
            if (lastExp) begin
              sum_q      <= accum_d;
              sumValid_q <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          sumValid_q <= 1'b0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (i_recip_valid) begin
            recip_q <= i_recip;
            idx_q   <= '0;
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (canLoad) begin
            prob_q      <= prob_d;
            probLast_q  <= (idx_q == IDX_W'(NUM_ELEMS - 1));
            probValid_q <= 1'b1;
            idx_q       <= idx_q + 1'b1;
          end else if (probValid_q && i_prob_ready) begin
            probValid_q <= 1'b0;
          end
          // Final downstream handshake returns the block to idle.
          if (lastOut) begin
            probValid_q <= 1'b0;
            probLast_q  <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            state_q     <= S_ACCUM;
          end
        end
        default: state_q <= S_ACCUM;
      endcase
    end
  end

  // Storage only; contents after reset are never observed before being written.
  always_ff @(posedge i_clk) begin
    if (expFire) begin
      expBuf_q[cnt_q] <= i_exp;
    end
  end

  assign o_exp_ready  = (state_q == S_ACCUM);
  assign o_sum_valid  = sumValid_q;
  assign o_sum        = sum_q;
  assign o_prob_valid = probValid_q;
  assign o_prob       = prob_q;
  assign o_prob_last  = probLast_q;
  assign o_busy       = !((state_q == S_ACCUM) && (cnt_q == '0));

endmodule

// File: tb/tb_softmax_sum_normalize.sv
// Directed bench for softmax_sum_normalize: drives vectors on the falling edge
// and samples outputs there, checking sums, probabilities, timing and stalls.
module tb_softmax_sum_normalize;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_exp_valid;
  logic [15:0] i_exp;
  logic        o_exp_ready;
  logic        o_sum_valid;
  logic [31:0] o_sum;
  logic        i_recip_valid;
  logic [15:0] i_recip;
  logic        o_prob_valid;
  logic [15:0] o_prob;
  logic        o_prob_last;
  logic        i_prob_ready;
  logic        o_busy;

  int checkCount = 0;
  int failCount  = 0;

  logic [15:0] vecExp    [32];
  logic [15:0] vecExpect [32];

  softmax_sum_normalize dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_exp_valid   (i_exp_valid),
    .i_exp         (i_exp),
    .o_exp_ready   (o_exp_ready),
    .o_sum_valid   (o_sum_valid),
    .o_sum         (o_sum),
    .i_recip_valid (i_recip_valid),
    .i_recip       (i_recip),
    .o_prob_valid  (o_prob_valid),
    .o_prob        (o_prob),
    .o_prob_last   (o_prob_last),
    .i_prob_ready  (i_prob_ready),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] roundMul(input logic [15:0] e, input logic [15:0] r);
    logic [31:0] p;
    p = 32'(e) * 32'(r) + 32'h8000;
    return p[31:16];
  endfunction

  // Sends vecExp, answers the sum request with recip, then drains the outputs.
  // abortAfter < 32 returns early (after that many output handshakes are issued).
  task automatic applyStimulus(input logic [15:0] recip, input int recipDelay,
                               input bit withGaps, input bit randomReady,
                               input bit spurious, input logic [31:0] expSum,
                               input int abortAfter);
    int          received;
    int          cyc;
    bit          stalled;
    logic [15:0] prevProb;
    logic        prevLast;
    for (int i = 0; i < 32; i++) vecExpect[i] = roundMul(vecExp[i], recip);

    for (int i = 0; i < 32; i++) begin
      if (withGaps && (i % 5 == 2)) begin
        i_exp_valid   = 1'b0;
        i_recip_valid = 1'b1;
        i_recip       = 16'hAAAA;
        @(negedge i_clk);
        i_recip_valid = 1'b0;
      end
      i_exp_valid = 1'b1;
      i_exp       = vecExp[i];
      if (i == 0 || i == 31) checkOutput("expReady", 32'(o_exp_ready), 32'd1);
      @(negedge i_clk);
    end
    i_exp_valid = spurious;
    i_exp       = 16'h1234;
    checkOutput("sumValid", 32'(o_sum_valid), 32'd1);
    checkOutput("sum", o_sum, expSum);
    @(negedge i_clk);
    checkOutput("sumPulse", 32'(o_sum_valid), 32'd0);
    checkOutput("readyWait", 32'(o_exp_ready), 32'd0);
    checkOutput("sumHold", o_sum, expSum);
    repeat (recipDelay) @(negedge i_clk);
    i_recip_valid = 1'b1;
    i_recip       = recip;
    @(negedge i_clk);
    i_recip_valid = 1'b0;
    i_recip       = 16'h0000;

    received = 0;
    stalled  = 1'b0;
    cyc      = 1;
    prevProb = '0;
    prevLast = 1'b0;
    while (received < 32 && cyc < 600) begin
      if (stalled) begin
        checkOutput("stallValid", 32'(o_prob_valid), 32'd1);
        checkOutput("stableProb", 32'(o_prob), 32'(prevProb));
        checkOutput("stableLast", 32'(o_prob_last), 32'(prevLast));
      end
      if (spurious) checkOutput("readyNorm", 32'(o_exp_ready), 32'd0);
      if (!randomReady && o_prob_valid && received == 0) checkOutput("firstLat", 32'(cyc), 32'd2);
      i_prob_ready = randomReady ? ($urandom_range(0, 2) != 0) : 1'b1;
      stalled = 1'b0;
      if (o_prob_valid) begin
        if (i_prob_ready) begin
          checkOutput("prob", 32'(o_prob), 32'(vecExpect[received]));
          checkOutput("last", 32'(o_prob_last), 32'(received == 31));
          if (!randomReady && received == 31) checkOutput("lastLat", 32'(cyc), 32'd33);
          received++;
          if (received == 32) i_exp_valid = 1'b0;
        end else begin
          stalled  = 1'b1;
          prevProb = o_prob;
          prevLast = o_prob_last;
        end
      end
      if (received == abortAfter && abortAfter < 32) return;
      @(negedge i_clk);
      cyc++;
    end
    i_prob_ready = 1'b1;
    checkOutput("allRecv", 32'(received), 32'd32);
    checkOutput("validDrop", 32'(o_prob_valid), 32'd0);
    checkOutput("readyBack", 32'(o_exp_ready), 32'd1);
    checkOutput("idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_exp_valid   = 1'b0;
    i_exp         = '0;
    i_recip_valid = 1'b0;
    i_recip       = '0;
    i_prob_ready  = 1'b1;
    repeat (2) @(negedge i_clk);
    checkOutput("rstSumValid", 32'(o_sum_valid), 32'd0);
    checkOutput("rstSum", o_sum, 32'd0);
    checkOutput("rstProbValid", 32'(o_prob_valid), 32'd0);
    checkOutput("rstProb", 32'(o_prob), 32'd0);
    checkOutput("rstLast", 32'(o_prob_last), 32'd0);
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("rstReady", 32'(o_exp_ready), 32'd1);

    $display("[TB] uniform vector");
    for (int i = 0; i < 32; i++) vecExp[i] = 16'h8000;
    applyStimulus(16'h0800, 4, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 32);
    for (int i = 0; i < 32; i++) checkOutput("uniformVal", 32'(vecExpect[i]), 32'h0400);

    $display("[TB] one-hot vector");
    for (int i = 0; i < 32; i++) vecExp[i] = (i == 0) ? 16'hFFFF : 16'h0000;
    applyStimulus(16'hFFFF, 0, 1'b0, 1'b0, 1'b0, 32'h03FF_FC00, 32);
    checkOutput("oneHotPeak", 32'(vecExpect[0]), 32'h0000_FFFE);

    $display("[TB] backpressure");
    for (int i = 0; i < 32; i++) vecExp[i] = 16'(16'h0400 * (i + 1));
    applyStimulus(16'h2001, 7, 1'b0, 1'b1, 1'b0, 32'h2100_0000, 32);
    checkOutput("roundedTop", 32'(vecExpect[31]), 32'h0000_1001);

    $display("[TB] gaps, spurious inputs, back-to-back");
    for (int i = 0; i < 32; i++) vecExp[i] = 16'(16'h0100 * i);
    applyStimulus(16'h0100, 3, 1'b1, 1'b0, 1'b1, 32'h07C0_0000, 32);
    for (int i = 0; i < 32; i++) vecExp[i] = 16'h8000;
    applyStimulus(16'h1000, 2, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 32);

    $display("[TB] reset during normalization");
    applyStimulus(16'h0800, 1, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 10);
    i_exp_valid = 1'b0;
    i_rst_n     = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(o_prob_valid), 32'd0);
    checkOutput("midRstProb", 32'(o_prob), 32'd0);
    checkOutput("midRstLast", 32'(o_prob_last), 32'd0);
    checkOutput("midRstSum", o_sum, 32'd0);
    checkOutput("midRstBusy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("postRstReady", 32'(o_exp_ready), 32'd1);
    @(negedge i_clk);
    applyStimulus(16'h0800, 2, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
